// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM state type and wait-counter sizing shared by the load/store unit.
package lsu_pkg;
  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  // The counter only has to hold 0..max_wait-1, so at least one bit.
  function automatic int cnt_width(input int max_wait);
    return max_wait < 2 ? 1 : $clog2(max_wait);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane steering / byte enables and load lane extraction / extension.
//   st_func, st_off, wdata -> be, st_data   (store side, fed from the live request)
//   ld_func, ld_off, rword -> ld_data       (load side, fed from the latched request)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_func,
  input  logic [1:0]  st_off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] st_data,
  input  logic [2:0]  ld_func,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rword,
  output logic [31:0] ld_data
);
  logic [31:0] lane;
  assign lane = rword >> {ld_off, 3'b000};
  always_comb begin
    be      = st_func[1:0] == 2'b00 ? 4'b0001 << st_off
            : st_func[1:0] == 2'b01 ? (st_off[1] ? 4'b1100 : 4'b0011)
            : 4'b1111;
    st_data = st_func[1:0] == 2'b00 ? {4{wdata[7:0]}}
            : st_func[1:0] == 2'b01 ? {2{wdata[15:0]}}
            : wdata;
    ld_data = ld_func == F_B  ? {{24{lane[7]}}, lane[7:0]}
            : ld_func == F_H  ? {{16{lane[15]}}, lane[15:0]}
            : ld_func == F_BU ? {24'b0, lane[7:0]}
            : ld_func == F_HU ? {16'b0, lane[15:0]}
            : lane;
  end
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between core and a variable-latency word memory.
//   core side : mem_read, mem_write, func, addr, wdata -> rdata, stall, fault
//   memory    : dm_req, dm_we, dm_addr, dm_be, dm_wdata -> dm_rdata, dm_ack
//   reset is asynchronous and active-low.
module lsu
  import lsu_pkg::*;
#(
  parameter int DM_ADDR_W = 8,
  parameter int MAX_WAIT  = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [2:0]           func,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 stall,
  output logic                 fault,
  output logic                 dm_req,
  output logic                 dm_we,
  output logic [DM_ADDR_W-1:0] dm_addr,
  output logic [3:0]           dm_be,
  output logic [31:0]          dm_wdata,
  input  logic [31:0]          dm_rdata,
  input  logic                 dm_ack
);
  localparam int CW = cnt_width(MAX_WAIT);
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    func_q;
  logic [1:0]    off_q;
  logic          to_q;
  logic [3:0]    st_be;
  logic [31:0]   st_data, ld_data;
  logic          func_ok, aligned, legal, bad, idle, acc, done, ack, tmo;
  logic          unused;
  assign unused = ^addr[31:DM_ADDR_W+2];
  lsu_align u_align (
    .st_func(func),   .st_off(addr[1:0]), .wdata(wdata),    .be(st_be), .st_data(st_data),
    .ld_func(func_q), .ld_off(off_q),     .rword(dm_rdata), .ld_data(ld_data)
  );
  assign func_ok = func inside {F_B, F_H, F_W} || (mem_read && func inside {F_BU, F_HU});
  assign aligned = func[1:0] == 2'b01 ? !addr[0] : func[1:0] == 2'b10 ? addr[1:0] == 2'b00 : 1'b1;
  assign legal   = (mem_read ^ mem_write) && func_ok && aligned;
  assign bad     = (mem_read || mem_write) && !legal;
  assign idle    = state == IDLE;
  assign acc     = state == ACCESS;
  assign done    = state == DONE;
  assign ack     = acc && dm_ack;
  assign tmo     = acc && !dm_ack && cnt == CW'(MAX_WAIT - 1);
  // Gated by reset so both drop the instant reset asserts, even with a request held.
  assign stall   = reset && ((idle && legal) || acc);
  assign fault   = reset && ((idle && bad) || (done && to_q));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      func_q   <= '0;
      off_q    <= '0;
      to_q     <= 1'b0;
      rdata    <= '0;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_be    <= '0;
      dm_wdata <= '0;
    end else if (idle && legal) begin
      state    <= ACCESS;
      cnt      <= '0;
      func_q   <= func;
      off_q    <= addr[1:0];
      to_q     <= 1'b0;
      dm_req   <= 1'b1;
      dm_we    <= mem_write;
      dm_addr  <= addr[DM_ADDR_W+1:2];
      dm_be    <= mem_write ? st_be : 4'b0000;
      dm_wdata <= st_data;
    end else if (ack || tmo) begin
      state  <= DONE;
      dm_req <= 1'b0;
      to_q   <= tmo;
      if (!dm_we) rdata <= ack ? ld_data : '0;
    end else if (acc) begin
      cnt <= cnt + 1'b1;
    end else if (done) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu.
module tb_lsu;
  import lsu_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  func = 3'b0;
  logic [31:0] addr = '0, wdata = '0, dm_rdata = '0;
  logic        dm_ack = 1'b0;
  logic [31:0] rdata, dm_wdata;
  logic        stall, fault, dm_req, dm_we;
  logic [7:0]  dm_addr;
  logic [3:0]  dm_be;
  int          n_cmp = 0, n_bad = 0, n_req;
  always #5 clk = ~clk;
  lsu #(.DM_ADDR_W(8), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .func(func),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .fault(fault),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask
  // Present a legal request in an IDLE cycle, ack in the k-th ACCESS cycle, stop at DONE (negedge).
  task automatic xfer(input logic rd, input logic wr, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] dr, input int k,
                      input logic [3:0] ebe, input logic [31:0] ewd);
    mem_read = rd; mem_write = wr; func = f; addr = a; wdata = wd; dm_rdata = dr;
    @(negedge clk);
    chk("stall_c0", stall, 1);
    chk("req_c0", dm_req, 0);
    for (int i = 1; i <= k; i++) begin
      @(posedge clk); #1;
      dm_ack = (i == k);
      @(negedge clk);
      chk("req_acc", dm_req, 1);
      chk("stall_acc", stall, 1);
      chk("dm_we", dm_we, wr);
      chk("dm_addr", dm_addr, a[9:2]);
      chk("dm_be", dm_be, ebe);
      if (wr) chk("dm_wdata", dm_wdata, ewd);
    end
    @(posedge clk); #1;
    dm_ack = 1'b0;
    @(negedge clk);
    chk("stall_done", stall, 0);
    chk("fault_done", fault, 0);
    chk("req_done", dm_req, 0);
  endtask
  task automatic idle();
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
  endtask
  initial begin
    #2;
    chk("rst_rdata", rdata, 0);
    chk("rst_req", dm_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_fault", fault, 0);
    chk("rst_be", dm_be, 0);
    chk("rst_addr", dm_addr, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    xfer(1, 0, F_B, 32'h13, 0, 32'h80FF_1234, 1, 4'b0000, 0);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    idle();
    xfer(1, 0, F_HU, 32'h2, 0, 32'hBEEF_0000, 2, 4'b0000, 0);
    chk("lhu_rdata", rdata, 32'h0000_BEEF);
    idle();
    xfer(1, 0, F_H, 32'h2, 0, 32'hBEEF_0000, 1, 4'b0000, 0);
    chk("lh_rdata", rdata, 32'hFFFF_BEEF);
    idle();
    xfer(0, 1, F_B, 32'h5, 32'h0000_00AB, 32'h5555_5555, 1, 4'b0010, 32'hABAB_ABAB);
    chk("sb_rdata_kept", rdata, 32'hFFFF_BEEF);
    idle();
    xfer(0, 1, F_H, 32'h6, 32'h0000_1234, 0, 3, 4'b1100, 32'h1234_1234);
    idle();
    // Illegal requests: misaligned LW, read+write, store with BU.
    for (int t = 0; t < 3; t++) begin
      mem_read  = (t != 2);
      mem_write = (t != 0);
      func      = t == 2 ? F_BU : F_W;
      addr      = t == 0 ? 32'h2 : 32'h0;
      @(negedge clk);
      chk("ill_fault", fault, 1);
      chk("ill_stall", stall, 0);
      chk("ill_req", dm_req, 0);
      @(posedge clk); #1;
      chk("ill_req_next", dm_req, 0);
      chk("ill_rdata", rdata, 32'hFFFF_BEEF);
    end
    idle();
    // Reset in the middle of an access.
    mem_read = 1'b1; func = F_W; addr = 32'hC;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_req", dm_req, 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_req", dm_req, 0);
    chk("arst_stall", stall, 0);
    chk("arst_rdata", rdata, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle();
    xfer(0, 1, F_W, 32'h10, 32'hDEAD_BEEF, 0, 1, 4'b1111, 32'hDEAD_BEEF);
    chk("sw_rdata_kept", rdata, 0);
    idle();
    xfer(1, 0, F_W, 32'h8, 0, 32'h1234_5678, 1, 4'b0000, 0);
    chk("lw_rdata", rdata, 32'h1234_5678);
    idle();
    // Timeout: no ack at all.
    mem_read = 1'b1; func = F_W; addr = 32'h8; dm_rdata = 32'hCAFE_F00D;
    n_req = 0;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!dm_req) break;
      n_req++;
    end
    chk("to_req_cycles", n_req, 15);
    chk("to_fault", fault, 1);
    chk("to_stall", stall, 0);
    chk("to_rdata", rdata, 0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    dm_ack = 1'b1;
    @(negedge clk);
    chk("late_fault", fault, 0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    @(negedge clk);
    chk("late_req", dm_req, 0);
    chk("late_stall", stall, 0);
    chk("late_rdata", rdata, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the datapath core and the data memory. It takes the core's memory request: the ALU result as the address, the rs2 value as store data, and funct3 as the access size. It drives a single-outstanding-transaction handshake to a variable-latency word-wide data memory and stalls the core until the access completes. It returns the aligned, sign- or zero-extended load word that feeds the core's RD_data writeback mux.

## Interface
Parameters:
- DM_ADDR_W, 8, word-address width of data memory (byte address bits [DM_ADDR_W+1:2]).
- MAX_WAIT, 15, maximum cycles to wait for dm_ack before timeout fault (1..255).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- mem_read  in  1  load request, held by core while stall=1.
- mem_write  in  1  store request, held by core while stall=1.
- func  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2).
- rdata  out  32  formatted load data, registered.
- stall  out  1  core must hold PC/state.
- fault  out  1  access rejected or timed out.
- dm_req  out  1  memory request, registered.
- dm_we  out  1  1=write.
- dm_addr  out  DM_ADDR_W  word address = addr[DM_ADDR_W+1:2].
- dm_be  out  4  byte enables (write only; 0000 on reads).
- dm_wdata  out  32  lane-steered store data.
- dm_rdata  in  32  read word, valid with dm_ack.
- dm_ack  in  1  one-cycle completion strobe.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: a request is mem_read^mem_write and legal, i.e. func valid for direction and aligned (H: addr[0]=0; W: addr[1:0]=0).
  - On a request: latch addr/func/direction and steered wdata/be, clear wait counter, go ACCESS.
  - Illegal request: mem_read&mem_write, bad func, misaligned, store with func 100/101.
  - On an illegal request: fault=1 that cycle, stall=0, no memory access, rdata unchanged.
- ACCESS: dm_req=1 with latched dm_we/dm_addr/dm_be/dm_wdata held stable.
  - On dm_ack: for loads, rdata <= formatted(dm_rdata); go DONE.
  - With no ack: counter++.
  - If counter reaches MAX_WAIT with no ack: rdata <= 0, set timeout flag, go DONE.
- DONE: stall=0; fault=timeout flag; core commits this cycle; next state IDLE. The still-present request is ignored in DONE.
- stall = (IDLE & legal request) | ACCESS.
- Store steering:
  - SB: be=0001<<addr[1:0], data={4{wdata[7:0]}}.
  - SH: be=addr[1]?1100:0011, data={2{wdata[15:0]}}.
  - SW: be=1111, data=wdata.
- Load formatting: lane = dm_rdata >> (8*addr[1:0]); B/H sign-extend bit 7/15; BU/HU zero-extend; W unchanged.
- dm_ack outside ACCESS is ignored.

## Timing
- Reset values: rdata=0, dm_req=0, dm_we=0, dm_addr=0, dm_be=0, dm_wdata=0, fault=0, stall=0, state IDLE.
- Reset asserted mid-ACCESS: dm_req drops asynchronously and the transaction is abandoned.
- Minimum access: request seen cycle 0 (stall=1); dm_req cycle 1; dm_ack cycle 1; DONE cycle 2 with rdata valid and stall=0. That is 3 core cycles.
- Ack in the k-th ACCESS cycle: DONE at cycle k+1.
- Timeout: dm_req high for exactly MAX_WAIT cycles, then DONE with fault=1.
- rdata holds its value until the next load completes. Stores and faults do not modify it, except a timed-out load, which writes 0.
- Back-to-back: a new request is accepted in the IDLE cycle immediately after DONE.

## Structure
- Package lsu_pkg holds:
  - funct3 constants F_B, F_H, F_W, F_BU, F_HU.
  - State enum IDLE/ACCESS/DONE.
  - MAX_WAIT counter width derivation.
- One combinational sub-module, lsu_align, performs store lane steering/byte-enable generation and load extraction/extension. It is shared by the latch path and the rdata capture path.
- Top module: FSM, wait counter, output registers.

## Test plan
- LB at addr 0x0000_0013, dm_rdata=0x80FF_1234, ack in first ACCESS cycle. Required: dm_addr=0x04, rdata=0xFFFF_FF80 in DONE (cycle 2), stall high for cycles 0–1.
- LHU at addr 0x2 with dm_rdata=0xBEEF_0000 → rdata=0x0000_BEEF. LH at the same address → rdata=0xFFFF_BEEF.
- SB addr 0x5 wdata=0x0000_00AB → dm_we=1, dm_be=0010, dm_wdata=0xABAB_ABAB. SH addr 0x6 → dm_be=1100.
- LW at addr 0x2 (misaligned), then mem_read&mem_write together. Required for both: fault=1 and stall=0 in the same cycle, dm_req never rises, rdata unchanged.
- LW with dm_ack withheld, MAX_WAIT=15. Required: dm_req high for 15 cycles, then DONE with fault=1 and rdata=0. A late dm_ack arriving afterwards is ignored.
- Reset pulled low during ACCESS. Required: dm_req and stall fall without waiting for a clock edge. After release, a fresh SW completes normally.
